sdram_port_arb: RTL and testbench
=================================

Name: sdram_port_arb

Overview:
- Parametrised N-port request arbiter that shares one SDRAM controller core between several AXI-to-RAM bridges.
- Each slave port carries the pmem-style request/ack RAM interface: addr, wr strobes, rd, len, write data, accept, ack, error, read data.
- The master port drives the core's inport.
- Adds burst-locked round-robin or fixed-priority arbitration, plus in-order response routing through a grant-tag FIFO.

Parameters:
- NUM_PORTS, 2, number of slave request ports (2..8).
- DATA_W, 32, data width; BE_W = DATA_W/8.
- ADDR_W, 32, address width.
- RESP_DEPTH, 8, outstanding-request FIFO depth (power of 2, ≥2).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_wr_i  in  NUM_PORTS*BE_W  per-port write byte strobes (non-zero = write request).
- in_rd_i  in  NUM_PORTS  per-port read request.
- in_len_i  in  NUM_PORTS*8  per-port burst length minus one.
- in_addr_i  in  NUM_PORTS*ADDR_W  per-port address.
- in_write_data_i  in  NUM_PORTS*DATA_W  per-port write data.
- in_accept_o  out  NUM_PORTS  request accepted this cycle.
- in_ack_o  out  NUM_PORTS  response beat for this port.
- in_error_o  out  NUM_PORTS  error qualifier with ack.
- in_read_data_o  out  NUM_PORTS*DATA_W  read data (valid with ack).
- out_wr_o / out_rd_o / out_len_o / out_addr_o / out_write_data_o  out  BE_W/1/8/ADDR_W/DATA_W  muxed request to core.
- out_accept_i  in  1  core accepted request.
- out_ack_i / out_error_i / out_read_data_i  in  1/1/DATA_W  core response.
- busy_o  out  1  FIFO non-empty or burst lock held.
- err_unexpected_o  out  1  sticky: ack received with FIFO empty.

Behaviour:
- A port requests when |wr or rd is set. Requests must be held stable until accepted.
- Every accepted request yields exactly one ack, in acceptance order.
- Grant is combinational when unlocked:
  - ARB_MODE 0: the first requesting port searching cyclically from last_grant+1.
  - ARB_MODE 1: the lowest-index requesting port.
- The out_* request fields mirror the granted port in the same cycle; there is no added request latency.
- When no port is granted, out_wr_o=0 and out_rd_o=0.
- in_accept_o[g] = out_accept_i & grant_valid & !fifo_full. Ungranted ports always see 0.
- When the FIFO is full, out_wr_o and out_rd_o are forced to 0. A simultaneous ack pop does not unblock in the same cycle.
- Burst lock:
  - On accept of a request with len=L>0 and lock clear, set lock, hold the grant on that port and load beat_cnt=L.
  - Each further accept from that port decrements beat_cnt. Lock clears on the accept that takes beat_cnt to 0.
  - While locked, other ports are never granted, even if the locked port drops its request.
- last_grant updates on the first accept of each burst (or of each len=0 request).
- Response FIFO: on accept, push the granted port index (width clog2(NUM_PORTS), min 1).
  - On out_ack_i, pop the head and route to that port: in_ack_o[head]=1, in_error_o[head]=out_error_i.
  - out_read_data_i is broadcast to every in_read_data_o slice; it is valid only where ack=1.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- out_ack_i with the FIFO empty: the ack is dropped (no in_ack_o) and err_unexpected_o is set. Only rst clears it.
- Reset values: lock=0, beat_cnt=0, last_grant=NUM_PORTS-1 (so port 0 wins first), FIFO empty, busy_o=0, err_unexpected_o=0, in_ack_o=0, in_error_o=0. Request-side outputs follow the combinational rules above.
- Reset mid-burst or with outstanding requests discards all state. Any later stray acks set err_unexpected_o.
- Pointer arithmetic wraps modulo RESP_DEPTH. The count is clog2(RESP_DEPTH)+1 bits.

Test Plan:
- Two ports, ARB_MODE 0, both issue len=0 reads continuously, out_accept_i=1, ack 2 cycles later → grants alternate 0,1,0,1; each port receives an in_ack_o on its own responses only, in order.
- Port 1 write burst len=3 (4 beats) while port 0 requests at beat 1 → port 0 is accepted only after port 1's 4th accept; busy_o is high throughout.
- ARB_MODE 1, ports 0 and 1 both always requesting → port 1 is never accepted while port 0 requests.
- RESP_DEPTH=4, no acks, port 0 issues 6 reads → exactly 4 accepted, then out_rd_o=0. Single ack → a 5th accept on the following cycle.
- Ack pulse with nothing outstanding after reset → no in_ack_o; err_unexpected_o=1 until rst.
- Assert rst mid-burst (beat_cnt=2) → lock clears, FIFO empties, the next grant goes to port 0 under round-robin.

Source files
------------

// File: rtl/sdram_port_arb.sv
// ============================================================================
// Module   : sdram_port_arb
// Purpose  : N-port request arbiter in front of one SDRAM core, with
//            burst-locked round-robin/fixed-priority grant and in-order acks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_port_arb #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int RESP_DEPTH = 8,
    parameter int ARB_MODE   = 0
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [NUM_PORTS*(DATA_W/8)-1:0] in_wr_i,
    input  logic [NUM_PORTS-1:0]          in_rd_i,
    input  logic [NUM_PORTS*8-1:0]        in_len_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]   in_addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_write_data_i,
    output logic [NUM_PORTS-1:0]          in_accept_o,
    output logic [NUM_PORTS-1:0]          in_ack_o,
    output logic [NUM_PORTS-1:0]          in_error_o,
    output logic [NUM_PORTS*DATA_W-1:0]   in_read_data_o,

    output logic [(DATA_W/8)-1:0]         out_wr_o,
    output logic                          out_rd_o,
    output logic [7:0]                    out_len_o,
    output logic [ADDR_W-1:0]             out_addr_o,
    output logic [DATA_W-1:0]             out_write_data_o,
    input  logic                          out_accept_i,
    input  logic                          out_ack_i,
    input  logic                          out_error_i,
    input  logic [DATA_W-1:0]             out_read_data_i,

    output logic                          busy_o,
    output logic                          err_unexpected_o
);

    localparam int BE_W   = DATA_W / 8;
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PTR_W  = $clog2(RESP_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [CNT_W-1:0]  C_FIFO_FULL  = CNT_W'(RESP_DEPTH);
    localparam logic [PORT_W-1:0] C_LAST_RESET = PORT_W'(NUM_PORTS - 1);

    // Arbitration state
    logic              lock_q,       lock_d;
    logic [PORT_W-1:0] lock_port_q,  lock_port_d;
    logic [7:0]        beat_cnt_q,   beat_cnt_d;
    logic [PORT_W-1:0] last_grant_q, last_grant_d;

    // Response tag FIFO
    logic [PORT_W-1:0] mem_q [RESP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              err_q,    err_d;

    logic [NUM_PORTS-1:0] w_req;
    logic [PORT_W-1:0]    w_grant;
    logic                 w_grant_valid;
    int                   w_idx;
    logic [BE_W-1:0]      w_sel_wr;
    logic                 w_sel_rd;
    logic [7:0]           w_sel_len;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic [PORT_W-1:0]    w_head;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            assign w_req[p]       = (|in_wr_i[p*BE_W +: BE_W]) | in_rd_i[p];
            assign in_accept_o[p] = w_accept && (w_grant == PORT_W'(p));
            assign in_ack_o[p]    = w_pop && (w_head == PORT_W'(p));
            assign in_error_o[p]  = w_pop && (w_head == PORT_W'(p)) && out_error_i;
            assign in_read_data_o[p*DATA_W +: DATA_W] = out_read_data_i;
        end
    endgenerate

    // A held lock pins the grant even when its owner stops requesting,
    // so w_grant_valid then drops and nobody else gets through.
    always_comb begin
        w_grant       = '0;
        w_grant_valid = 1'b0;
        w_idx         = 0;
        if (lock_q) begin
            w_grant       = lock_port_q;
            w_grant_valid = w_req[lock_port_q];
        end else if (ARB_MODE == 1) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (w_req[i]) begin
                    w_grant       = PORT_W'(i);
                    w_grant_valid = 1'b1;
                end
            end
        end else begin
            // Descending scan: the last hit is the one nearest after last_grant.
            for (int i = NUM_PORTS; i >= 1; i--) begin
                w_idx = int'(last_grant_q) + i;
                if (w_idx >= NUM_PORTS) begin
                    w_idx = w_idx - NUM_PORTS;
                end
                if (w_req[w_idx]) begin
                    w_grant       = PORT_W'(w_idx);
                    w_grant_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_sel_wr         = in_wr_i[int'(w_grant)*BE_W +: BE_W];
        w_sel_rd         = in_rd_i[w_grant];
        w_sel_len        = in_len_i[int'(w_grant)*8 +: 8];
        out_addr_o       = in_addr_i[int'(w_grant)*ADDR_W +: ADDR_W];
        out_write_data_o = in_write_data_i[int'(w_grant)*DATA_W +: DATA_W];
        out_len_o        = w_sel_len;
        out_wr_o         = '0;
        out_rd_o         = 1'b0;
        if (w_grant_valid && !w_full) begin
            out_wr_o = w_sel_wr;
            out_rd_o = w_sel_rd;
        end
    end

    assign w_full   = (count_q == C_FIFO_FULL);
    assign w_empty  = (count_q == '0);
    assign w_accept = out_accept_i && w_grant_valid && !w_full;
    assign w_push   = w_accept;
    assign w_pop    = out_ack_i && !w_empty;
    assign w_head   = mem_q[rd_ptr_q];

    assign busy_o           = !w_empty || lock_q;
    assign err_unexpected_o = err_q;

    always_comb begin
        lock_d       = lock_q;
        lock_port_d  = lock_port_q;
        beat_cnt_d   = beat_cnt_q;
        last_grant_d = last_grant_q;
        if (w_accept) begin
            if (lock_q) begin
                beat_cnt_d = beat_cnt_q - 8'd1;
                if (beat_cnt_q == 8'd1) begin
                    lock_d = 1'b0;
                end
            end else begin
                last_grant_d = w_grant;
                if (w_sel_len != 8'd0) begin
                    lock_d      = 1'b1;
                    lock_port_d = w_grant;
                    beat_cnt_d  = w_sel_len;
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | (out_ack_i & w_empty);
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (w_push && !w_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q       <= 1'b0;
            lock_port_q  <= '0;
            beat_cnt_q   <= 8'd0;
            last_grant_q <= C_LAST_RESET;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            lock_port_q  <= lock_port_d;
            beat_cnt_q   <= beat_cnt_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_q        <= err_d;
        end
    end

    // Tag storage needs no reset: only entries below count_q are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_grant;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sdram_port_arb.sv
// ============================================================================
// Module   : tb_sdram_port_arb
// Purpose  : Directed self-checking bench for sdram_port_arb (RR and fixed).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdram_port_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wr0, wr1;
    logic        rd0, rd1;
    logic [7:0]  len0, len1;
    logic [31:0] addr0, addr1;
    logic        out_accept, out_ack, out_error;
    logic [31:0] out_rdata;

    logic [7:0]  in_wr;
    logic [1:0]  in_rd;
    logic [15:0] in_len;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;

    assign in_wr    = {wr1, wr0};
    assign in_rd    = {rd1, rd0};
    assign in_len   = {len1, len0};
    assign in_addr  = {addr1, addr0};
    assign in_wdata = {32'h0000_00B1, 32'h0000_00A0};

    logic [1:0]  rr_accept, rr_ack, rr_error;
    logic [63:0] rr_rdata;
    logic [3:0]  rr_wr;
    logic        rr_rd;
    logic [7:0]  rr_len;
    logic [31:0] rr_addr, rr_wdata;
    logic        rr_busy, rr_err;

    logic [1:0]  fp_accept, fp_ack, fp_error;
    logic [63:0] fp_rdata;
    logic [3:0]  fp_wr;
    logic        fp_rd;
    logic [7:0]  fp_len;
    logic [31:0] fp_addr, fp_wdata;
    logic        fp_busy, fp_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sdram_port_arb #(.NUM_PORTS(2), .DATA_W(32), .ADDR_W(32), .RESP_DEPTH(4), .ARB_MODE(0)) u_rr (
        .clk(clk), .rst(rst),
        .in_wr_i(in_wr), .in_rd_i(in_rd), .in_len_i(in_len), .in_addr_i(in_addr),
        .in_write_data_i(in_wdata), .in_accept_o(rr_accept), .in_ack_o(rr_ack),
        .in_error_o(rr_error), .in_read_data_o(rr_rdata),
        .out_wr_o(rr_wr), .out_rd_o(rr_rd), .out_len_o(rr_len), .out_addr_o(rr_addr),
        .out_write_data_o(rr_wdata), .out_accept_i(out_accept), .out_ack_i(out_ack),
        .out_error_i(out_error), .out_read_data_i(out_rdata),
        .busy_o(rr_busy), .err_unexpected_o(rr_err)
    );

    sdram_port_arb #(.NUM_PORTS(2), .DATA_W(32), .ADDR_W(32), .RESP_DEPTH(8), .ARB_MODE(1)) u_fp (
        .clk(clk), .rst(rst),
        .in_wr_i(in_wr), .in_rd_i(in_rd), .in_len_i(in_len), .in_addr_i(in_addr),
        .in_write_data_i(in_wdata), .in_accept_o(fp_accept), .in_ack_o(fp_ack),
        .in_error_o(fp_error), .in_read_data_o(fp_rdata),
        .out_wr_o(fp_wr), .out_rd_o(fp_rd), .out_len_o(fp_len), .out_addr_o(fp_addr),
        .out_write_data_o(fp_wdata), .out_accept_i(out_accept), .out_ack_i(out_ack),
        .out_error_i(out_error), .out_read_data_i(out_rdata),
        .busy_o(fp_busy), .err_unexpected_o(fp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wr0 = '0; wr1 = '0; rd0 = 1'b0; rd1 = 1'b0;
        len0 = '0; len1 = '0; addr0 = '0; addr1 = '0;
        out_accept = 1'b0; out_ack = 1'b0; out_error = 1'b0; out_rdata = '0;
        #2;
        chk("reset_busy", rr_busy, 0);
        chk("reset_err", rr_err, 0);
        chk("reset_ack", rr_ack, 0);
        chk("reset_out_rd", rr_rd, 0);
        chk("reset_out_wr", rr_wr, 0);
        next();
        rst = 1'b0;

        // Round-robin alternation with len=0 reads, acks two cycles behind
        rd0 = 1'b1; addr0 = 32'h100;
        rd1 = 1'b1; addr1 = 32'h200;
        out_accept = 1'b1;
        #1;
        chk("rr_c0_accept", rr_accept, 2'b01);
        chk("rr_c0_addr", rr_addr, 32'h100);
        chk("rr_c0_rd", rr_rd, 1);
        chk("fp_c0_accept", fp_accept, 2'b01);
        next();
        chk("rr_c1_accept", rr_accept, 2'b10);
        chk("rr_c1_addr", rr_addr, 32'h200);
        chk("rr_c1_wdata", rr_wdata, 32'h0000_00B1);
        chk("fp_c1_accept", fp_accept, 2'b01);
        next();
        out_ack = 1'b1; out_rdata = 32'hCAFE_0001;
        #1;
        chk("rr_c2_accept", rr_accept, 2'b01);
        chk("rr_c2_ack", rr_ack, 2'b01);
        chk("rr_c2_rdata", rr_rdata, 64'hCAFE_0001_CAFE_0001);
        chk("fp_c2_accept", fp_accept, 2'b01);
        chk("fp_c2_ack", fp_ack, 2'b01);
        next();
        chk("rr_c3_accept", rr_accept, 2'b10);
        chk("rr_c3_ack", rr_ack, 2'b10);
        next();
        rd0 = 1'b0; rd1 = 1'b0; out_error = 1'b1;
        #1;
        chk("rr_c4_ack", rr_ack, 2'b01);
        chk("rr_c4_error", rr_error, 2'b01);
        chk("rr_c4_out_rd", rr_rd, 0);
        next();
        out_error = 1'b0;
        #1;
        chk("rr_c5_ack", rr_ack, 2'b10);
        chk("rr_c5_error", rr_error, 2'b00);
        chk("rr_c5_busy", rr_busy, 1);
        next();
        out_ack = 1'b0;
        #1;
        chk("rr_drain_busy", rr_busy, 0);
        chk("fp_drain_busy", fp_busy, 0);

        // Port 1 write burst of 4 beats; port 0 joins at beat 1
        wr1 = 4'hF; len1 = 8'd3; addr1 = 32'h300;
        #1;
        chk("burst_b0_accept", rr_accept, 2'b10);
        chk("burst_b0_wr", rr_wr, 4'hF);
        chk("burst_b0_len", rr_len, 8'd3);
        chk("fp_burst_b0_accept", fp_accept, 2'b10);
        next();
        rd0 = 1'b1; addr0 = 32'h100; out_ack = 1'b1;
        #1;
        chk("burst_b1_accept", rr_accept, 2'b10);
        chk("burst_b1_busy", rr_busy, 1);
        chk("burst_b1_addr", rr_addr, 32'h300);
        chk("burst_b1_ack", rr_ack, 2'b10);
        chk("fp_burst_b1_accept", fp_accept, 2'b10);
        next();
        chk("burst_b2_accept", rr_accept, 2'b10);
        chk("burst_b2_busy", rr_busy, 1);
        next();
        chk("burst_b3_accept", rr_accept, 2'b10);
        chk("burst_b3_busy", rr_busy, 1);
        next();
        wr1 = 4'h0; len1 = 8'd0;
        #1;
        chk("after_burst_accept", rr_accept, 2'b01);
        chk("after_burst_rd", rr_rd, 1);
        chk("after_burst_ack", rr_ack, 2'b10);
        chk("fp_after_burst_accept", fp_accept, 2'b01);
        next();
        rd0 = 1'b0;
        #1;
        chk("after_burst_ack_p0", rr_ack, 2'b01);
        next();
        out_ack = 1'b0;
        #1;
        chk("after_burst_idle", rr_busy, 0);

        // FIFO full: depth 4, no acks, port 0 keeps reading
        rd0 = 1'b1; addr0 = 32'h400;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("full_fill_accept", rr_accept, 2'b01);
            next();
        end
        chk("full_out_rd", rr_rd, 0);
        chk("full_accept", rr_accept, 2'b00);
        next();
        out_ack = 1'b1;
        #1;
        chk("full_pop_ack", rr_ack, 2'b01);
        chk("full_pop_no_accept", rr_accept, 2'b00);
        next();
        out_ack = 1'b0;
        #1;
        chk("full_reopen_accept", rr_accept, 2'b01);
        chk("full_reopen_rd", rr_rd, 1);
        next();
        rd0 = 1'b0;

        // Reset with outstanding requests, then a stray ack
        rst = 1'b1;
        #1;
        chk("rst_clears_busy", rr_busy, 0);
        next();
        rst = 1'b0;
        out_ack = 1'b1;
        #1;
        chk("stray_no_ack", rr_ack, 2'b00);
        chk("stray_err_before_edge", rr_err, 0);
        next();
        out_ack = 1'b0;
        #1;
        chk("stray_err_set", rr_err, 1);
        next();
        chk("stray_err_sticky", rr_err, 1);

        // Reset mid-burst at beat_cnt=2
        wr1 = 4'hF; len1 = 8'd3; addr1 = 32'h500;
        out_accept = 1'b1;
        #1;
        chk("rstb_b0_accept", rr_accept, 2'b10);
        next();
        chk("rstb_b1_accept", rr_accept, 2'b10);
        next();
        rd0 = 1'b1; addr0 = 32'h600;
        #1;
        chk("rstb_locked_accept", rr_accept, 2'b10);
        chk("rstb_err_held", rr_err, 1);
        rst = 1'b1;
        #1;
        chk("rstb_async_busy", rr_busy, 0);
        chk("rstb_async_err", rr_err, 0);
        next();
        rst = 1'b0;
        #1;
        chk("rstb_grant_p0", rr_accept, 2'b01);
        chk("rstb_addr_p0", rr_addr, 32'h600);
        chk("fp_rstb_grant_p0", fp_accept, 2'b01);
        next();
        rd0 = 1'b0; wr1 = 4'h0; len1 = 8'd0; out_accept = 1'b0;
        next();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
